piso_shift_ctrl: RTL and testbench
==================================

Name: piso_shift_ctrl

Overview:
Sequencer for a parallel-in/serial-out shift register built from D-type flip-flops. It accepts a parallel word on a start request and shifts it out one bit per clock. It tracks the bit count and signals completion with a one-cycle pulse. It sits between a parallel producer and a serial sink, such as a lab UART-style or SPI-style output stage.

Parameters:
WIDTH, 8, word length in bits; legal range 2..32
LSB_FIRST, 1, 1 = shift out bit 0 first (shift right); 0 = bit WIDTH-1 first (shift left)

Ports:
clk  input  1  clock; all state updates on its rising edge
rst  input  1  reset; synchronous, active-high
start  input  1  request to load data_in and begin a frame; sampled only in IDLE
abort  input  1  terminate the current frame; sampled only in SHIFT
data_in  input  WIDTH  parallel word; captured on the edge that accepts start
ready  output  1  high in IDLE; controller can accept start
busy  output  1  high in SHIFT
sdo  output  1  serial data out
sdo_valid  output  1  high while sdo carries a frame bit (equals busy)
done  output  1  one-cycle pulse after the last bit of a completed frame

Behaviour:
- Reset:
  - Synchronous: takes effect only on a clk edge with rst=1 and overrides all other inputs.
  - After reset: state=IDLE, shift register=0, bit counter=0.
  - Output values: ready=1, busy=0, sdo=0, sdo_valid=0, done=0.
- Registers:
  - state (2 bits), shreg (WIDTH bits), cnt ($clog2(WIDTH) bits), done flag.
  - All registers use non-blocking assignment.
- Output derivation:
  - ready, busy and sdo_valid decode directly from state.
  - sdo = shreg[0] if LSB_FIRST, else shreg[WIDTH-1].
  - sdo is forced to 0 in IDLE.
  - done is a registered flag.
- IDLE:
  - start=1 at an edge: shreg<=data_in, cnt<=0, state<=SHIFT.
  - The first bit is on sdo in the cycle immediately after that edge, so latency is 1 cycle.
  - abort has no effect in IDLE.
- SHIFT:
  - Each edge shifts shreg by one position toward the output end, filling with 0, and sets cnt<=cnt+1.
  - start is ignored and data_in is not sampled.
  - At an edge with cnt==WIDTH-1: state<=IDLE and done<=1.
  - SHIFT therefore lasts exactly WIDTH cycles, with sdo_valid high for exactly WIDTH cycles.
- done:
  - High for exactly one cycle, coincident with the first IDLE cycle (ready=1).
  - Cleared on the next edge unconditionally.
- Back-to-back frames:
  - start may be high during the done cycle and is accepted.
  - Minimum inter-frame gap is 1 idle cycle; maximum throughput is WIDTH bits per WIDTH+1 cycles.
- Abort:
  - abort=1 in SHIFT: next edge state<=IDLE, cnt<=0, shreg<=0, and no done pulse.
  - If abort coincides with the last bit (cnt==WIDTH-1), abort wins and done stays 0.
- Reset mid-frame: the frame is discarded, no done pulse, and all outputs return to reset values on the next edge.
- Unreachable state encodings return to IDLE on the next edge.
- Widths:
  - cnt is wide enough for WIDTH-1 and never wraps within a frame.
  - The comparison uses the parameter-derived constant WIDTH-1.

Decomposition:
- Shared package: state encodings as localparams (ST_IDLE=2'b00, ST_SHIFT=2'b01).
- Shared package also holds a counter-width helper based on $clog2(WIDTH).
- One sub-module is natural: piso_shreg.
  - Function: WIDTH-bit loadable shift register with load, shift_en and LSB_FIRST parameter, plus the synchronous reset.
  - The controller FSM and counter stay in piso_shift_ctrl.

Test Plan:
- Reset check: hold rst=1 for 3 cycles with start=1 -> ready=1, busy=0, sdo=0, done=0 throughout; no frame begins until rst drops.
- LSB-first frame (WIDTH=8, LSB_FIRST=1): data_in=8'h2D, 1-cycle start -> sdo = 1,0,1,1,0,1,0,0 on the 8 cycles after the accept edge, with sdo_valid=1 on exactly those cycles. done=1 on cycle 9 only, and ready=1 on cycle 9.
- MSB-first frame (LSB_FIRST=0): data_in=8'h2D -> sdo = 0,0,1,0,1,1,0,1. data_in changed to 8'hFF mid-frame -> no effect on sdo.
- Back-to-back frames: start held high continuously, data_in=8'h81 then 8'h7E -> two frames of 8 valid bits each, separated by exactly one cycle with done=1 and sdo_valid=0.
- Abort:
  - abort pulsed on the 4th shift cycle -> IDLE next cycle, sdo=0, no done pulse.
  - abort on the 8th (last) bit cycle -> no done pulse.
- Reset mid-frame: rst=1 for one edge during bit 5 -> next cycle busy=0, sdo=0, done=0; a new start afterwards produces a clean full frame.

Source files
------------

// File: rtl/piso_shift_ctrl_pkg.sv
// Shared definitions for the PISO shift sequencer: state encodings and counter sizing.
package piso_shift_ctrl_pkg;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_SHIFT = 2'b01;

  // Bit-counter width able to hold WIDTH-1 (at least one bit).
  function automatic int cnt_w(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/piso_shift_ctrl_shreg.sv
// Loadable WIDTH-bit shift register; zero-fills toward the far end and presents the output-end bit.
module piso_shreg #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] data_in,
  output logic             out_bit
);

  logic [WIDTH-1:0] shreg_q, shreg_d;

  always_comb begin
    shreg_d = shreg_q;
    if (clr) begin
      shreg_d = '0;
    end else if (load) begin
      shreg_d = data_in;
    end else if (shift_en) begin
      if (LSB_FIRST) shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
      else           shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) shreg_q <= '0;
    else     shreg_q <= shreg_d;
  end

  assign out_bit = LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1];

endmodule

// File: rtl/piso_shift_ctrl.sv
// Parallel-in/serial-out sequencer: loads a word on start, emits one bit per clock, pulses done.
//   state    | meaning
//   ST_IDLE  | ready for start; sdo held at 0; done may be high for one cycle
//   ST_SHIFT | one frame bit on sdo per cycle, cnt = index of the bit shown
module piso_shift_ctrl
  import piso_shift_ctrl_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] data_in,
  output logic             ready,
  output logic             busy,
  output logic             sdo,
  output logic             sdo_valid,
  output logic             done
);

  localparam int          CW       = cnt_w(WIDTH);
  localparam int unsigned LAST_I   = WIDTH - 1;
  localparam logic [CW-1:0] CNT_LAST = LAST_I[CW-1:0];

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic          load, shift_en, clr;
  logic          out_bit;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    load     = 1'b0;
    shift_en = 1'b0;
    clr      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (abort) begin
          // Abort beats completion, even on the last bit.
          clr     = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          shift_en = 1'b1;
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: begin
        clr     = 1'b1;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  piso_shreg #(
    .WIDTH     (WIDTH),
    .LSB_FIRST (LSB_FIRST)
  ) u_shreg (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .load     (load),
    .shift_en (shift_en),
    .data_in  (data_in),
    .out_bit  (out_bit)
  );

  assign ready     = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_SHIFT);
  assign sdo_valid = busy;
  assign sdo       = busy & out_bit;
  assign done      = done_q;

endmodule

// File: tb/tb_piso_shift_ctrl.sv
// Bench: LSB-first and MSB-first instances share stimulus and are checked each cycle against a frame-level model.
module tb_piso_shift_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, start, abort;
  logic [W-1:0] data_in;
  logic         ready0, busy0, sdo0, vld0, done0;
  logic         ready1, busy1, sdo1, vld1, done1;

  int errs   = 0;
  int checks = 0;

  // Frame-level model: which word is in flight and which bit index is on the wire.
  bit           m_active = 1'b0;
  bit           m_done   = 1'b0;
  logic [W-1:0] m_word   = '0;
  int           m_pos    = 0;

  always #5 clk = ~clk;

  piso_shift_ctrl #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_lsb (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .data_in(data_in),
    .ready(ready0), .busy(busy0), .sdo(sdo0), .sdo_valid(vld0), .done(done0));

  piso_shift_ctrl #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .data_in(data_in),
    .ready(ready1), .busy(busy1), .sdo(sdo1), .sdo_valid(vld1), .done(done1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_step();
    if (rst) begin
      m_active = 1'b0; m_done = 1'b0; m_pos = 0;
    end else if (m_active) begin
      m_done = 1'b0;
      if (abort) m_active = 1'b0;
      else if (m_pos == W-1) begin m_active = 1'b0; m_done = 1'b1; end
      else m_pos++;
    end else begin
      m_done = 1'b0;
      if (start) begin m_active = 1'b1; m_word = data_in; m_pos = 0; end
    end
  endtask

  task automatic check_all();
    logic e_lsb, e_msb;
    e_lsb = m_active ? m_word[m_pos] : 1'b0;
    e_msb = m_active ? m_word[W-1-m_pos] : 1'b0;
    chk("lsb.ready", ready0, !m_active);
    chk("lsb.busy",  busy0,  m_active);
    chk("lsb.valid", vld0,   m_active);
    chk("lsb.sdo",   sdo0,   e_lsb);
    chk("lsb.done",  done0,  m_done);
    chk("msb.ready", ready1, !m_active);
    chk("msb.busy",  busy1,  m_active);
    chk("msb.valid", vld1,   m_active);
    chk("msb.sdo",   sdo1,   e_msb);
    chk("msb.done",  done1,  m_done);
  endtask

  task automatic tick(input logic r, input logic s, input logic a, input logic [W-1:0] d);
    rst = r; start = s; abort = a; data_in = d;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  initial begin
    logic [W-1:0] got_lsb, got_msb;
    int n_vld, n_done;
    rst = 1'b1; start = 1'b0; abort = 1'b0; data_in = '0;

    // Reset held with start asserted: nothing may begin.
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b1, 1'b0, 8'hA5);
      chk("rst.ready", ready0, 1'b1);
      chk("rst.busy",  busy0,  1'b0);
    end
    tick(1'b0, 1'b0, 1'b0, 8'h00);

    // Single frame of 8'h2D; data_in corrupted mid-frame must not matter.
    got_lsb = '0; got_msb = '0;
    tick(1'b0, 1'b1, 1'b0, 8'h2D);
    for (int k = 0; k < W; k++) begin
      got_lsb[k] = sdo0;
      got_msb    = {got_msb[W-2:0], sdo1};
      chk("frame.vld", vld0, 1'b1);
      tick(1'b0, 1'b0, 1'b0, (k >= 3) ? 8'hFF : 8'h2D);
    end
    chk("frame.lsb_bits", got_lsb, 8'h2D);
    chk("frame.msb_bits", got_msb, 8'h2D);
    chk("frame.done9",  done0,  1'b1);
    chk("frame.ready9", ready0, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 8'h00);
    chk("frame.done_clr", done0, 1'b0);

    // Back-to-back with start held: 0x81 then 0x7E.
    n_vld = 0; n_done = 0;
    for (int k = 0; k < 18; k++) begin
      tick(1'b0, 1'b1, 1'b0, (k < 9) ? 8'h81 : 8'h7E);
      n_vld  += vld0;
      n_done += done0;
    end
    chk("b2b.vld_cnt",  n_vld,  16);
    chk("b2b.done_cnt", n_done, 2);
    tick(1'b0, 1'b0, 1'b0, 8'h00);

    // Abort on the 4th shift cycle.
    tick(1'b0, 1'b1, 1'b0, 8'hFF);
    for (int k = 0; k < 3; k++) tick(1'b0, 1'b0, 1'b0, 8'h00);
    tick(1'b0, 1'b0, 1'b1, 8'h00);
    chk("abort4.busy", busy0, 1'b0);
    chk("abort4.sdo",  sdo1,  1'b0);
    tick(1'b0, 1'b0, 1'b0, 8'h00);
    chk("abort4.done", done0, 1'b0);

    // Abort on the last bit suppresses done.
    tick(1'b0, 1'b1, 1'b0, 8'hC3);
    for (int k = 0; k < W-1; k++) tick(1'b0, 1'b0, 1'b0, 8'h00);
    tick(1'b0, 1'b0, 1'b1, 8'h00);
    chk("abort8.done", done0, 1'b0);
    chk("abort8.done_msb", done1, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 8'h00);

    // Reset during bit 5, then a clean frame.
    tick(1'b0, 1'b1, 1'b0, 8'hB6);
    for (int k = 0; k < 5; k++) tick(1'b0, 1'b0, 1'b0, 8'h00);
    tick(1'b1, 1'b0, 1'b0, 8'h00);
    chk("midrst.busy", busy0, 1'b0);
    chk("midrst.done", done0, 1'b0);
    got_lsb = '0;
    tick(1'b0, 1'b1, 1'b0, 8'h5C);
    for (int k = 0; k < W; k++) begin
      got_lsb[k] = sdo0;
      tick(1'b0, 1'b0, 1'b0, 8'h00);
    end
    chk("midrst.refrm", got_lsb, 8'h5C);
    chk("midrst.done_after", done0, 1'b1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      tick(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 45),
           ($urandom_range(0, 99) < 6), W'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
